// File: rtl/affine_interp_pkg.sv
// Shared constants for the affine interpolation filter.
// Holds the tap count, phase width, rounding constants and the
// 8-tap quarter-pel coefficient table. Each row of the table sums to 64.
// COEF[frac][i] is the coefficient applied to window sample s[i].
package affine_interp_pkg;

    localparam int unsigned NTAPS     = 8;
    localparam int unsigned FRAC_BITS = 2;
    localparam int unsigned SHIFT     = 6;
    localparam int unsigned ROUND     = 32;

    typedef logic [FRAC_BITS-1:0] frac_t;

    localparam int COEF [4][8] = '{
        '{ 0, 0,   0, 64,  0,   0, 0,  0},
        '{-1, 4, -10, 58, 17,  -5, 1,  0},
        '{-1, 4, -11, 40, 40, -11, 4, -1},
        '{ 0, 1,  -5, 17, 58, -10, 4, -1}
    };

    function automatic int coef_mag(input int c);
        return (c < 0) ? -c : c;
    endfunction

endpackage

// File: rtl/interp_tap_mcm.sv
// Per-tap multiple-constant multiplier, purely combinational.
// Builds the coefficient multiples with shifts and adds, then picks the
// one for this tap and phase and negates it for negative coefficients.
// Multiples not used by this tap's column of COEF are removed by
// constant propagation, since TAP is fixed per instance.
// Ports:
//   sample  - unsigned reference sample (zero-extended internally)
//   frac    - quarter-pel phase of the beat
//   product - signed coefficient * sample, SUM_W bits
module interp_tap_mcm
    import affine_interp_pkg::*;
#(
    parameter int unsigned BIT_DEPTH = 10,
    parameter int unsigned SUM_W     = BIT_DEPTH + 9,
    parameter int unsigned TAP       = 0
) (
    input  logic [BIT_DEPTH-1:0]    sample,
    input  frac_t                   frac,
    output logic signed [SUM_W-1:0] product
);

    logic signed [SUM_W-1:0] x1, x4, x5, x10, x11, x17, x40, x58, x64;
    logic signed [SUM_W-1:0] mag;
    int c;

    assign x1  = $signed({{(SUM_W-BIT_DEPTH){1'b0}}, sample});
    assign x4  = x1 <<< 2;
    assign x5  = x4 + x1;
    assign x10 = x5 <<< 1;
    assign x11 = x10 + x1;
    assign x17 = (x1 <<< 4) + x1;
    assign x40 = x5 <<< 3;
    assign x58 = (x1 <<< 6) - (x1 <<< 2) - (x1 <<< 1);
    assign x64 = x1 <<< 6;

    always_comb begin
        c = COEF[frac][TAP];
        case (coef_mag(c))
            1:       mag = x1;
            4:       mag = x4;
            5:       mag = x5;
            10:      mag = x10;
            11:      mag = x11;
            17:      mag = x17;
            40:      mag = x40;
            58:      mag = x58;
            64:      mag = x64;
            default: mag = '0;
        endcase
        product = (c < 0) ? -mag : mag;
    end

endmodule

// File: rtl/affine_interp_filter.sv
// Streaming 8-tap quarter-pel horizontal interpolation filter.
// A sliding window of the last 8 accepted samples feeds one MCM per tap;
// products, pairwise sums and the rounded/clipped result are registered
// in three stages behind the window register. A stalled output freezes
// the whole pipeline, so in_ready is simply the inverse of that stall.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - input handshake
//   in_sample             - unsigned reference sample
//   in_first, frac        - row start marker and the row's phase
//   out_valid/out_ready   - output handshake
//   out_sample            - interpolated, clipped sample
module affine_interp_filter
    import affine_interp_pkg::*;
#(
    parameter int unsigned BIT_DEPTH = 10,
    parameter int unsigned SUM_W     = BIT_DEPTH + 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_DEPTH-1:0] in_sample,
    input  logic                 in_first,
    input  logic [1:0]           frac,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_DEPTH-1:0] out_sample
);

    localparam logic signed [SUM_W-1:0] RND  = SUM_W'(ROUND);
    localparam logic signed [SUM_W-1:0] MAXV =
        {{(SUM_W-BIT_DEPTH){1'b0}}, {BIT_DEPTH{1'b1}}};

    logic [BIT_DEPTH-1:0]    win [NTAPS];
    logic [3:0]              fill, fill_nxt;
    frac_t                   row_frac, beat_frac, win_frac;
    logic                    stall, accept;
    logic                    v0, v1, v2;
    logic signed [SUM_W-1:0] prod   [NTAPS];
    logic signed [SUM_W-1:0] prod_r [NTAPS];
    logic signed [SUM_W-1:0] pair_r [NTAPS/2];
    logic signed [SUM_W-1:0] total, rounded;
    logic [BIT_DEPTH-1:0]    clipped;

    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready;
    assign beat_frac = in_first ? frac : row_frac;

    always_comb begin
        fill_nxt = fill;
        if (in_first)
            fill_nxt = 4'd1;
        else if (fill != 4'(NTAPS))
            fill_nxt = fill + 4'd1;
    end

    // Products are taken from the registered window with the phase that
    // entered alongside the newest sample, so a row change mid-flight
    // never mixes phases.
    for (genvar g = 0; g < NTAPS; g++) begin : g_tap
        interp_tap_mcm #(
            .BIT_DEPTH(BIT_DEPTH),
            .SUM_W    (SUM_W),
            .TAP      (g)
        ) u_mcm (
            .sample (win[g]),
            .frac   (win_frac),
            .product(prod[g])
        );
    end

    always_comb begin
        total   = pair_r[0] + pair_r[1] + pair_r[2] + pair_r[3];
        rounded = (total + RND) >>> SHIFT;
        if (rounded[SUM_W-1])
            clipped = '0;
        else if (rounded > MAXV)
            clipped = '1;
        else
            clipped = rounded[BIT_DEPTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill       <= '0;
            row_frac   <= '0;
            win_frac   <= '0;
            v0         <= 1'b0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            for (int unsigned i = 0; i < NTAPS; i++) begin
                win[i]    <= '0;
                prod_r[i] <= '0;
            end
            for (int unsigned k = 0; k < NTAPS/2; k++)
                pair_r[k] <= '0;
        end else if (!stall) begin
            if (accept) begin
                for (int unsigned i = 0; i < NTAPS-1; i++)
                    win[i] <= win[i+1];
                win[NTAPS-1] <= in_sample;
                fill         <= fill_nxt;
                win_frac     <= beat_frac;
                if (in_first)
                    row_frac <= frac;
            end
            v0 <= accept && (fill_nxt == 4'(NTAPS));

            for (int unsigned i = 0; i < NTAPS; i++)
                prod_r[i] <= prod[i];
            v1 <= v0;

            for (int unsigned k = 0; k < NTAPS/2; k++)
                pair_r[k] <= prod_r[2*k] + prod_r[2*k+1];
            v2 <= v1;

            out_valid <= v2;
            if (v2)
                out_sample <= clipped;
        end
    end

endmodule

// File: tb/tb_affine_interp_filter.sv
module tb_affine_interp_filter;
    import affine_interp_pkg::*;

    localparam int unsigned BD = 10;
    localparam int MAXS = 1023;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_first = 1'b0;
    logic          out_ready = 1'b1;
    logic [1:0]    frac = 2'd0;
    logic [BD-1:0] in_sample = '0;
    logic          in_ready, out_valid;
    logic [BD-1:0] out_sample;

    affine_interp_filter #(.BIT_DEPTH(BD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .in_first  (in_first),
        .frac      (frac),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sample(out_sample)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int m_win[8];
    int m_cnt = 0;
    int m_rowfrac = 0;
    int t_fill = -1;
    int t_rise = -100;
    logic prev_ov = 1'b0;
    logic [BD-1:0] held;

    typedef struct {
        int f;
        int s[8];
        int e;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int golden(input int f, input int w[8]);
        int sum = 0;
        int r;
        for (int i = 0; i < 8; i++) sum += COEF[f][i] * w[i];
        r = (sum + int'(ROUND)) >>> int'(SHIFT);
        if (r < 0) r = 0;
        if (r > MAXS) r = MAXS;
        return r;
    endfunction

    // Scoreboard consumer: every handshaked output must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !prev_ov) t_rise = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    chk("spurious_output", int'(out_sample), -1);
                else
                    chk("out_sample", int'(out_sample), exp_q.pop_front());
            end
        end
        prev_ov = out_valid;
    end

    task automatic send_beat(input int s, input bit first, input int f, input bit push);
        bit acc = 0;
        in_valid  = 1'b1;
        in_sample = BD'(s);
        in_first  = first;
        frac      = 2'(f);
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < 7; i++) m_win[i] = m_win[i+1];
        m_win[7] = s;
        if (first) begin
            m_cnt = 1;
            m_rowfrac = f;
        end else if (m_cnt < 8) begin
            m_cnt++;
        end
        if (m_cnt == 8) begin
            if (t_fill < 0) t_fill = cyc;
            if (push) exp_q.push_back(golden(m_rowfrac, m_win));
        end
    endtask

    task automatic send_row(input int f, input int s[$], input bit push);
        for (int i = 0; i < s.size(); i++) send_beat(s[i], i == 0, f, push);
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(negedge clk);
        chk("drain_remaining", exp_q.size(), 0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m_win[i] = 0;
        m_cnt = 0;
        m_rowfrac = 0;
        exp_q.delete();
    endtask

    int q[$];

    initial begin
        for (int i = 0; i < 8; i++) m_win[i] = 0;

        vt[0] = '{2, '{100, 100, 100, 100, 100, 100, 100, 100}, 100};
        vt[1] = '{1, '{0, 1023, 0, 1023, 1023, 0, 1023, 0}, 1023};
        vt[2] = '{0, '{0, 1, 2, 3, 4, 5, 6, 7}, 3};
        vt[3] = '{3, '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023}, 1023};
        vt[4] = '{2, '{0, 0, 0, 1023, 0, 0, 0, 0}, 639};
        vt[5] = '{1, '{1023, 0, 0, 0, 0, 0, 0, 0}, 0};
        vt[6] = '{3, '{0, 0, 0, 0, 1023, 0, 0, 0}, 927};
        vt[7] = '{2, '{1023, 1023, 1023, 0, 0, 1023, 1023, 1023}, 0};

        do_reset(3);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_sample", int'(out_sample), 0);
        chk("reset_in_ready", int'(in_ready), 1);

        // Constant row, phase 2, plus fill-to-output latency.
        t_fill = -1;
        repeat (5) exp_q.push_back(100);
        q = {};
        repeat (12) q.push_back(100);
        send_row(2, q, 0);
        drain();
        chk("latency", t_rise - t_fill, 3);

        // Ramp at phase 0 picks s[3].
        for (int v = 3; v <= 11; v++) exp_q.push_back(v);
        q = {};
        for (int v = 0; v < 16; v++) q.push_back(v);
        send_row(0, q, 0);
        drain();

        // Impulse response at phase 1, negative taps clip to 0.
        exp_q.push_back(0);   exp_q.push_back(16); exp_q.push_back(0); exp_q.push_back(266);
        exp_q.push_back(906); exp_q.push_back(0);  exp_q.push_back(63); exp_q.push_back(0);
        q = {};
        for (int v = 0; v < 15; v++) q.push_back(v == 7 ? 1000 : 0);
        send_row(1, q, 0);
        drain();

        // Single-window vectors with hand-derived results.
        for (int n = 0; n < 8; n++) begin
            exp_q.push_back(vt[n].e);
            q = {};
            for (int i = 0; i < 8; i++) q.push_back(vt[n].s[i]);
            send_row(vt[n].f, q, 0);
            drain();
        end

        // Five-cycle output stall in the middle of a continuous row.
        q = {};
        for (int v = 0; v < 20; v++) q.push_back(int'($urandom_range(0, MAXS)));
        fork
            send_row(1, q, 1);
            begin
                repeat (12) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (i == 0) held = out_sample;
                    chk("stall_out_valid", int'(out_valid), 1);
                    chk("stall_in_ready", int'(in_ready), 0);
                    chk("stall_out_sample_hold", int'(out_sample), int'(held));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with outputs in flight drops them.
        q = {};
        for (int v = 0; v < 10; v++) q.push_back(int'($urandom_range(0, MAXS)));
        send_row(2, q, 1);
        do_reset(1);
        chk("reset2_out_valid", int'(out_valid), 0);
        chk("reset2_out_sample", int'(out_sample), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("reset2_quiet", int'(out_valid), 0);

        // Partial row, reset, then a fresh phase-3 row.
        q = {};
        for (int v = 0; v < 5; v++) q.push_back(int'($urandom_range(0, MAXS)));
        send_row(1, q, 1);
        do_reset(1);
        chk("reset3_out_valid", int'(out_valid), 0);
        chk("reset3_in_ready", int'(in_ready), 1);
        q = {};
        for (int v = 0; v < 10; v++) q.push_back(int'($urandom_range(0, MAXS)));
        send_row(3, q, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
